// File: rtl/qbus_pkg.sv
// qbus_pkg: shared Qbus state encodings, default window/wait settings and byte-enable helper
package qbus_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SEL, S_RD, S_WR, S_RPLY, S_ERR} qbus_state_t;
  localparam logic [2:0] QBUS_BASE_DEFAULT = 3'b000;
  localparam int QBUS_WAIT_DEFAULT = 0;
  function automatic logic [1:0] qbus_byte_en(input logic wtbt, input logic hi);
    return wtbt ? (hi ? 2'b10 : 2'b01) : 2'b11;
  endfunction
endpackage

// File: rtl/qbus_ram.sv
// qbus_ram: 4096x16 synchronous single-port RAM with byte enables and one-cycle read latency
module qbus_ram (
  input  logic        clk,
  input  logic        i_en,
  input  logic [1:0]  i_we,
  input  logic [11:0] i_addr,
  input  logic [15:0] i_d,
  output logic [15:0] o_q
);
  logic [15:0] r_mem [0:4095];
  logic [15:0] r_q;
  assign o_q = r_q;
  // byte-lane writes and registered read; contents are never reset
  always_ff @(posedge clk) begin
    if (i_we[0]) r_mem[i_addr][7:0] <= i_d[7:0];
    if (i_we[1]) r_mem[i_addr][15:8] <= i_d[15:8];
    if (i_en) r_q <= r_mem[i_addr];
  end
endmodule

// File: rtl/qbus_mem_slave.sv
// qbus_mem_slave: Qbus memory slave with an 8K-byte window, programmable reply wait states
module qbus_mem_slave
  import qbus_pkg::*;
#(
  parameter logic [2:0] BASE = QBUS_BASE_DEFAULT,
  parameter int         WAIT = QBUS_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        sync,
  input  logic        din,
  input  logic        dout,
  input  logic        wtbt,
  input  logic [15:0] ad_in,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  output logic        rply,
  output logic        err
);
  qbus_state_t r_state;
  logic [11:0] r_addr;
  logic        r_byte;
  logic        r_is_rd;
  logic [2:0]  r_cnt;
  logic [15:0] r_ad_out;
  logic        r_oe;
  logic        r_rply;
  logic        r_err;
  logic        w_hit;
  logic        w_idle_eval;
  logic        w_both;
  logic        w_sel;
  logic        w_rd;
  logic [1:0]  w_we;
  logic [15:0] w_q;
  assign w_hit       = sync && ad_in[15:13] == BASE;
  assign w_idle_eval = r_state == S_IDLE || (sync && r_state != S_SEL);
  assign w_both      = !din && !dout;
  assign w_sel       = r_state == S_SEL && !init;
  assign w_rd        = w_sel && !din && dout;
  assign w_we        = (w_sel && !dout && din) ? qbus_byte_en(wtbt, r_byte) : 2'b00;
  assign ad_out      = r_ad_out;
  assign ad_oe       = r_oe;
  assign rply        = r_rply;
  assign err         = r_err;
  qbus_ram u_ram (
    .clk    (clk),
    .i_en   (w_rd),
    .i_we   (w_we),
    .i_addr (r_addr),
    .i_d    (ad_in),
    .o_q    (w_q)
  );
  // bus cycle sequencer; a read enters RPLY one edge early so the reply lands WAIT+2 edges after din
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_byte   <= 1'b0;
      r_is_rd  <= 1'b0;
      r_cnt    <= '0;
      r_ad_out <= '0;
      r_oe     <= 1'b0;
      r_rply   <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (init) begin
        r_state <= S_IDLE;
        r_rply  <= 1'b1;
        r_oe    <= 1'b0;
      end else if (w_idle_eval) begin
        r_rply  <= 1'b1;
        r_oe    <= 1'b0;
        r_state <= w_hit ? S_SEL : S_IDLE;
        if (w_hit) begin
          r_addr <= ad_in[12:1];
          r_byte <= ad_in[0];
        end
      end else begin
        case (r_state)
          S_SEL: begin
            if (w_both) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else if (!din || !dout) begin
              r_state <= !din ? S_RD : S_WR;
              r_is_rd <= !din;
              r_cnt   <= 3'(WAIT);
            end
          end
          S_RD, S_WR: begin
            if (w_both) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else if (r_cnt != 3'd0) begin
              r_cnt <= r_cnt - 3'd1;
            end else begin
              r_state <= S_RPLY;
              if (r_state == S_RD) r_ad_out <= w_q;
              else r_rply <= 1'b0;
            end
          end
          S_RPLY: begin
            if (r_is_rd ? !din : !dout) begin
              r_rply <= 1'b0;
              r_oe   <= r_is_rd;
            end else begin
              r_rply  <= 1'b1;
              r_oe    <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          S_ERR: r_state <= (din && dout) ? S_IDLE : S_ERR;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_qbus_mem_slave.sv
// tb_qbus_mem_slave: directed table-driven checks of the Qbus memory slave at WAIT=0 and WAIT=3
module tb_qbus_mem_slave;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init = 1'b0;
  logic        sync = 1'b0;
  logic        din = 1'b1;
  logic        dout = 1'b1;
  logic        wtbt = 1'b0;
  logic [15:0] ad = 16'h0000;
  logic [15:0] q0, q3;
  logic        oe0, oe3, rply0, rply3, err0, err3;
  logic        sel3 = 1'b0;
  logic        s_rply, s_oe;
  logic [15:0] s_q;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
    logic        bw;
    logic        rd;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [0:9];
  assign s_rply = sel3 ? rply3 : rply0;
  assign s_oe   = sel3 ? oe3 : oe0;
  assign s_q    = sel3 ? q3 : q0;
  always #5 clk = ~clk;
  qbus_mem_slave #(.BASE(3'b000), .WAIT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .init(init), .sync(sync), .din(din), .dout(dout),
    .wtbt(wtbt), .ad_in(ad), .ad_out(q0), .ad_oe(oe0), .rply(rply0), .err(err0)
  );
  qbus_mem_slave #(.BASE(3'b000), .WAIT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .init(init), .sync(sync), .din(din), .dout(dout),
    .wtbt(wtbt), .ad_in(ad), .ad_out(q3), .ad_oe(oe3), .rply(rply3), .err(err3)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic xfer(input logic [15:0] a, input logic [15:0] d, input logic bw,
                      input logic rd, input logic [15:0] exp, input logic s3);
    int n;
    int w;
    sel3 = s3;
    w = s3 ? 3 : 0;
    sync = 1'b1;
    ad = a;
    step;
    sync = 1'b0;
    ad = rd ? a : d;
    wtbt = bw;
    if (rd) din = 1'b0;
    else dout = 1'b0;
    step;
    n = 0;
    do begin
      step;
      n++;
    end while (s_rply && n < 20);
    check(rd ? "read_latency" : "write_latency", n, rd ? w + 2 : w + 1);
    check("reply_oe", {31'd0, s_oe}, {31'd0, rd});
    if (rd) check("read_data", {16'd0, s_q}, {16'd0, exp});
    din = 1'b1;
    dout = 1'b1;
    wtbt = 1'b0;
    step;
    check("release", {30'd0, s_rply, s_oe}, 32'd2);
    repeat (8) step;
  endtask
  initial begin
    int bad;
    int pulses;
    tbl[0] = '{16'h0100, 16'h1234, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{16'h0100, 16'h0000, 1'b0, 1'b1, 16'h1234};
    tbl[2] = '{16'h0101, 16'hAB00, 1'b1, 1'b0, 16'h0000};
    tbl[3] = '{16'h0100, 16'h0000, 1'b0, 1'b1, 16'hAB34};
    tbl[4] = '{16'h0101, 16'h0000, 1'b0, 1'b1, 16'hAB34};
    tbl[5] = '{16'h0200, 16'h5678, 1'b0, 1'b0, 16'h0000};
    tbl[6] = '{16'h0200, 16'h99EF, 1'b1, 1'b0, 16'h0000};
    tbl[7] = '{16'h0200, 16'h0000, 1'b0, 1'b1, 16'h56EF};
    tbl[8] = '{16'h1FFE, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
    tbl[9] = '{16'h1FFE, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
    repeat (3) step;
    check("reset_outputs", {12'd0, rply0, oe0, err0, q0, 1'b0, rply3}, {12'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1});
    rst_n = 1'b1;
    step;
    for (int i = 0; i <= 9; i++) xfer(tbl[i].a, tbl[i].d, tbl[i].bw, tbl[i].rd, tbl[i].exp, 1'b0);
    xfer(16'h0100, 16'h0000, 1'b0, 1'b1, 16'hAB34, 1'b1);
    xfer(16'h0300, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b1);
    xfer(16'h0300, 16'h0000, 1'b0, 1'b1, 16'h1111, 1'b0);
    sel3 = 1'b0;
    sync = 1'b1;
    ad = 16'h4000;
    step;
    sync = 1'b0;
    din = 1'b0;
    bad = 0;
    repeat (64) begin
      step;
      bad += (!rply0 || oe0 || !rply3 || oe3) ? 1 : 0;
    end
    check("outside_window", bad, 0);
    din = 1'b1;
    repeat (4) step;
    sync = 1'b1;
    ad = 16'h0100;
    step;
    sync = 1'b0;
    din = 1'b0;
    step;
    init = 1'b1;
    step;
    init = 1'b0;
    bad = 0;
    repeat (10) begin
      step;
      bad += !rply0 ? 1 : 0;
    end
    check("init_no_reply", bad, 0);
    din = 1'b1;
    repeat (4) step;
    xfer(16'h0100, 16'h0000, 1'b0, 1'b1, 16'hAB34, 1'b0);
    sync = 1'b1;
    ad = 16'h0100;
    step;
    sync = 1'b0;
    ad = 16'hFFFF;
    din = 1'b0;
    dout = 1'b0;
    step;
    check("err_pulse_sel", {31'd0, err0}, 32'd1);
    pulses = 0;
    bad = 0;
    repeat (8) begin
      step;
      pulses += err0 ? 1 : 0;
      bad += !rply0 ? 1 : 0;
    end
    check("err_single", pulses, 0);
    check("err_no_reply", bad, 0);
    din = 1'b1;
    dout = 1'b1;
    repeat (4) step;
    xfer(16'h0100, 16'h0000, 1'b0, 1'b1, 16'hAB34, 1'b0);
    sync = 1'b1;
    ad = 16'h0100;
    step;
    sync = 1'b0;
    din = 1'b0;
    step;
    dout = 1'b0;
    step;
    check("err_pulse_rd", {31'd0, err0}, 32'd1);
    din = 1'b1;
    dout = 1'b1;
    repeat (4) step;
    sync = 1'b1;
    ad = 16'h0100;
    step;
    sync = 1'b0;
    din = 1'b0;
    repeat (3) step;
    check("abort_pre_reply", {31'd0, rply0}, 32'd0);
    sync = 1'b1;
    ad = 16'h4000;
    step;
    check("sync_abort", {30'd0, rply0, oe0}, 32'd2);
    sync = 1'b0;
    din = 1'b1;
    repeat (8) step;
    sync = 1'b1;
    ad = 16'h0100;
    step;
    sync = 1'b0;
    din = 1'b0;
    repeat (3) step;
    check("mid_reset_pre", {31'd0, oe0}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_release", {14'd0, rply0, oe0, q0}, {14'd0, 1'b1, 1'b0, 16'h0000});
    step;
    rst_n = 1'b1;
    din = 1'b1;
    repeat (4) step;
    sync = 1'b1;
    ad = 16'h0100;
    step;
    sync = 1'b0;
    ad = 16'h0000;
    dout = 1'b0;
    #2 rst_n = 1'b0;
    step;
    check("reset_write_rply", {31'd0, rply0}, 32'd1);
    rst_n = 1'b1;
    dout = 1'b1;
    repeat (4) step;
    xfer(16'h0100, 16'h0000, 1'b0, 1'b1, 16'hAB34, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/qbus_mem_slave.md
QBUS_MEM_SLAVE -- requirements
Module: qbus_mem_slave

Interface
REQ-001 Parameter BASE, default 3'b000: window select, compared against ad_in[15:13].
REQ-002 Parameter WAIT, default 0, range 0..7: extra reply wait states.
REQ-003 clk  input  1  single system clock; all logic rises on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 init  input  1  bus init, active high, synchronous abort.
REQ-006 sync  input  1  high = address phase, ad_in carries the address.
REQ-007 din  input  1  low = read data strobe.
REQ-008 dout  input  1  low = write data strobe, ad_in carries the data.
REQ-009 wtbt  input  1  high during a dout strobe = byte write.
REQ-010 ad_in  input  16  address/data from the bus.
REQ-011 ad_out  output  16  read data to the bus.
REQ-012 ad_oe  output  1  high = top level drives ad with ad_out.
REQ-013 rply  output  1  low = slave reply; idles high.
REQ-014 err  output  1  one-cycle high pulse on a protocol error.

Function
REQ-015 All inputs are synchronous to clk; no synchroniser stages.
REQ-016 States: IDLE, SEL, RD, WR, RPLY, ERR.
REQ-017 IDLE: sync==1 and ad_in[15:13]==BASE -> latch word address ad_in[12:1] and byte bit ad_in[0], go SEL; outside the window -> stay IDLE, never reply.
REQ-018 SEL: din==0 and dout==1 -> RD, issue RAM read, load wait counter with WAIT.
REQ-019 SEL: dout==0 and din==1 -> WR, write RAM on this edge, load wait counter with WAIT.
REQ-020 Word write: both bytes written. Byte write (wtbt==1): byte bit 0 writes ad_in[7:0] to the low byte; byte bit 1 writes ad_in[15:8] to the high byte.
REQ-021 Read latency: rply=0 and ad_oe=1 from the (WAIT+2)th rising edge after the edge that samples din==0.
REQ-022 Write latency: rply=0 from the (WAIT+1)th rising edge after the edge that samples dout==0.
REQ-023 ad_out always returns the full 16-bit word, including on byte addresses.
REQ-024 RPLY: hold rply=0 (and ad_oe on reads) while the strobe stays low.
REQ-025 RPLY: on the first edge that samples the strobe high, set rply=1 and ad_oe=0 and go to IDLE.
REQ-026 din==0 and dout==0 together in SEL, RD or WR: go to ERR, pulse err, suppress rply and any pending write.
REQ-027 ERR: leave for IDLE when din==1 and dout==1.
REQ-028 sync==1 in any state other than IDLE or SEL aborts the cycle: release rply and ad_oe, then re-evaluate as IDLE on the same edge.
REQ-029 init==1: go to IDLE, rply=1, ad_oe=0; RAM contents preserved.
REQ-030 The wait counter saturates at 0; WAIT=0 adds no cycles.

Reset
REQ-031 rst_n low immediately forces state=IDLE, rply=1, ad_oe=0, ad_out=16'h0000, err=0, counter=0.
REQ-032 Reset does not clear RAM contents.
REQ-033 Reset asserted mid-cycle releases rply within the same reset assertion; no write completes after rst_n falls.

Structure
REQ-034 State encodings and the default BASE/WAIT values live in shared package qbus_pkg, reused by the bus master.
REQ-035 Storage is one sub-module, qbus_ram: synchronous single-port RAM, 4096x16, two byte enables, one-cycle read latency.

Verification
REQ-036 Write word 16'h1234 to 16'h0100, then read 16'h0100 -> ad_out=16'h1234; rply low 1 edge after dout and 2 edges after din (WAIT=0).
REQ-037 Byte write 16'hAB00 to 16'h0101 with wtbt=1 after REQ-036 -> read 16'h0100 returns 16'hAB34.
REQ-038 BASE=0, access to address 16'h4000 -> rply stays 1 and ad_oe stays 0 for 64 cycles.
REQ-039 WAIT=3, read 16'h0100 -> rply low exactly 5 edges after din is sampled low.
REQ-040 init=1 pulse while in RD -> rply never asserts; next read of 16'h0100 still returns 16'hAB34.
REQ-041 din=0 and dout=0 together after a valid address -> single err pulse, no rply, RAM word unchanged.
